// File: rtl/ifetch.sv
// Instruction fetch unit: paces ROM reads against a small tagged instruction
// buffer and flushes everything on a jump redirect.
`ifndef DataWidth
`define DataWidth 16
`endif

module ifetch #(
    parameter int WIDTH       = `DataWidth,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [WIDTH-1:0]       pc_i,
    output logic                   pc_load_o,
    output logic                   pc_inc_o,
    output logic [WIDTH-1:0]       pc_in_o,
    output logic                   rom_en_o,
    output logic [WIDTH-1:0]       rom_addr_o,
    input  logic [INSTR_WIDTH-1:0] rom_data_i,
    input  logic                   redirect_i,
    input  logic [WIDTH-1:0]       redirect_addr_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0]       instr_pc_o,
    input  logic                   instr_ready_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0]       addr_mem_q  [DEPTH];
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   inflight_q, inflight_d;
    logic [WIDTH-1:0]       inflight_addr_q, inflight_addr_d;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW-1:0] occupancy;

    // Handshake: the consumer takes the head entry on any cycle where
    // instr_valid_o and instr_ready_i are both high; valid never depends on ready,
    // and the head entry stays stable until it is taken or a redirect flushes it.
    assign pop  = instr_valid_o & instr_ready_i;
    assign push = inflight_q & ~redirect_i;

    // Entries already owed to the buffer (stored + in flight), net of this
    // cycle's pop; issuing only below DEPTH guarantees every response has a slot.
    assign occupancy = count_q + CW'(inflight_q) - CW'(pop);
    assign issue     = ~reset_i & ~redirect_i & (occupancy < CW'(DEPTH));

    assign rom_en_o   = issue;
    assign rom_addr_o = pc_i;
    assign pc_inc_o   = issue;
    assign pc_load_o  = ~reset_i & redirect_i;
    assign pc_in_o    = redirect_addr_i;

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? instr_mem_q[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? addr_mem_q[rd_ptr_q]  : '0;

    always_comb begin
        count_d         = count_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        inflight_d      = issue;
        inflight_addr_d = issue ? pc_i : inflight_addr_q;
        if (redirect_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                addr_mem_q[i]  <= '0;
            end
        end else begin
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= rom_data_i;
                addr_mem_q[wr_ptr_q]  <= inflight_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: PC and ROM models around the DUT, a program-order
// scoreboard for delivered instructions and an occupancy model for pacing.
module tb_ifetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [15:0] pc_q;
    logic        pc_load_o, pc_inc_o, rom_en_o;
    logic [15:0] pc_in_o, rom_addr_o;
    logic [15:0] rom_data;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_addr_i = 16'h0;
    logic        instr_valid_o;
    logic [15:0] instr_o, instr_pc_o;
    logic        instr_ready_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    logic [31:0] exp_q[$];
    logic [15:0] gen_next;
    int          m_cnt;
    int          m_infl;

    always #5 clk = ~clk;

    ifetch #(.WIDTH(16), .INSTR_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .pc_i(pc_q),
        .pc_load_o(pc_load_o),
        .pc_inc_o(pc_inc_o),
        .pc_in_o(pc_in_o),
        .rom_en_o(rom_en_o),
        .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data),
        .redirect_i(redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .instr_valid_o(instr_valid_o),
        .instr_o(instr_o),
        .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    function automatic logic [15:0] rom_f(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // Program counter with reset address 0.
    always @(posedge clk or posedge reset_i) begin
        if (reset_i)        pc_q <= 16'h0;
        else if (pc_load_o) pc_q <= pc_in_o;
        else if (pc_inc_o)  pc_q <= pc_q + 16'h1;
    end

    // Synchronous ROM: data one cycle after the enable, junk otherwise.
    always @(posedge clk) begin
        rom_data <= rom_en_o ? rom_f(rom_addr_o) : 16'hDEAD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back({gen_next, rom_f(gen_next)});
            gen_next = gen_next + 16'h1;
        end
    endtask

    // Monitor: samples mid-cycle, checks against the models, then advances them
    // to reflect the coming rising edge.
    always @(negedge clk) begin
        logic        e_valid, e_pop, e_issue;
        logic [31:0] e;
        if (reset_i) begin
            m_cnt  = 0;
            m_infl = 0;
            exp_q.delete();
            gen_next = 16'h0;
            chk("reset_valid", 32'(instr_valid_o), 32'd0);
            chk("reset_rom_en", 32'(rom_en_o), 32'd0);
        end else begin
            e_valid = (m_cnt != 0);
            e_pop   = e_valid && instr_ready_i;
            e_issue = !redirect_i && (m_cnt + m_infl - int'(e_pop) < DEPTH);
            chk("instr_valid", 32'(instr_valid_o), 32'(e_valid));
            chk("rom_en", 32'(rom_en_o), 32'(e_issue));
            chk("pc_inc", 32'(pc_inc_o), 32'(e_issue));
            chk("pc_load", 32'(pc_load_o), 32'(redirect_i));
            chk("pc_in", 32'(pc_in_o), 32'(redirect_addr_i));
            if (e_issue) chk("rom_addr", 32'(rom_addr_o), 32'(pc_q));
            if (!instr_valid_o) chk("empty_head", {instr_pc_o, instr_o}, 32'd0);
            if (instr_valid_o && instr_ready_i) begin
                top_up();
                e = exp_q.pop_front();
                chk("head_pc", 32'(instr_pc_o), 32'(e[31:16]));
                chk("head_instr", 32'(instr_o), 32'(e[15:0]));
                n_pops++;
            end
            if (redirect_i) begin
                m_cnt  = 0;
                m_infl = 0;
                exp_q.delete();
                gen_next = redirect_addr_i;
            end else begin
                m_cnt  = m_cnt - int'(e_pop) + m_infl;
                m_infl = int'(e_issue);
            end
            top_up();
        end
    end

    task automatic redirect_to(input logic [15:0] target);
        redirect_i      = 1'b1;
        redirect_addr_i = target;
        #1;
        chk("redir_pc_load", 32'(pc_load_o), 32'd1);
        chk("redir_pc_in", 32'(pc_in_o), 32'(target));
        chk("redir_rom_en", 32'(rom_en_o), 32'd0);
        step();
        redirect_i = 1'b0;
        chk("redir_flushed", 32'(instr_valid_o), 32'd0);
    endtask

    initial begin
        #1 reset_i = 1'b1;
        repeat (3) step();
        reset_i       = 1'b0;
        instr_ready_i = 1'b1;
        repeat (20) step();

        // Consumer stall mid-stream.
        instr_ready_i = 1'b0;
        repeat (5) step();
        chk("stall_issue_off", 32'(rom_en_o), 32'd0);
        chk("stall_head_valid", 32'(instr_valid_o), 32'd1);
        instr_ready_i = 1'b1;
        repeat (10) step();

        // Redirect while full and with a read in flight.
        instr_ready_i = 1'b0;
        step();
        redirect_to(16'h0040);
        instr_ready_i = 1'b1;
        repeat (10) step();

        // Redirect coincident with pop and a ROM response, then back-to-back.
        redirect_to(16'h0100);
        repeat (6) step();
        redirect_to(16'h0200);
        redirect_to(16'h0300);
        repeat (6) step();

        // Address wrap through 0xFFFF.
        redirect_to(16'hFFFE);
        repeat (8) step();

        // Randomised traffic with occasional redirects.
        for (int i = 0; i < 300; i++) begin
            instr_ready_i   = ($urandom_range(0, 3) != 0);
            redirect_addr_i = 16'($urandom_range(0, 16'hFFFF));
            redirect_i      = ($urandom_range(0, 19) == 0);
            step();
        end
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        repeat (5) step();

        // Asynchronous reset between edges.
        #3;
        reset_i = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid_o), 32'd0);
        chk("async_rom_en", 32'(rom_en_o), 32'd0);
        step();
        step();
        reset_i = 1'b0;
        repeat (12) step();

        chk("progress", 32'(n_pops > 200), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit sitting between the program counter and the instruction ROM. It drives the PC's load/inc controls, issues ROM reads at the current PC value, and buffers returned instructions in a small FIFO. The FIFO presents each instruction, tagged with its address, to the decode/execute stage over a valid/ready handshake. Jumps arrive as a redirect request that flushes buffered and in-flight instructions and reloads the PC.

## Interface
- `WIDTH`, default `` `DataWidth `` (16): address width and PC width.
- `INSTR_WIDTH`, default 16: instruction word width.
- `DEPTH`, default 2: instruction buffer entries; legal values are 2 and 4.
- `clk_i` input, 1 bit: the single clock. All state updates on its rising edge.
- `reset_i` input, 1 bit: asynchronous, active-high reset.
- `pc_i` input, `WIDTH` bits: current PC value (the PC's `out_o`).
- `pc_load_o` output, 1 bit: PC load control.
- `pc_inc_o` output, 1 bit: PC increment control.
- `pc_in_o` output, `WIDTH` bits: PC load value.
- `rom_en_o` output, 1 bit: ROM read enable.
- `rom_addr_o` output, `WIDTH` bits: ROM read address.
- `rom_data_i` input, `INSTR_WIDTH` bits: ROM read data. It is valid exactly 1 cycle after the matching `rom_en_o`.
- `redirect_i` input, 1 bit: jump request.
- `redirect_addr_i` input, `WIDTH` bits: jump target.
- `instr_valid_o` output, 1 bit: buffer head holds a valid instruction.
- `instr_o` output, `INSTR_WIDTH` bits: head instruction.
- `instr_pc_o` output, `WIDTH` bits: address of the head instruction.
- `instr_ready_i` input, 1 bit: consumer accepts the head instruction.

## Operation
- **State:**
  - FIFO of `DEPTH` entries, each holding {instr, addr}, with read pointer, write pointer and count.
  - In-flight flag `inflight`.
  - In-flight address register `inflight_addr`.
- **pop** = `instr_valid_o & instr_ready_i`.
- **Issue condition (normal):**
  - issue = `!redirect_i & (count + inflight - pop < DEPTH)`.
  - The subtraction is evaluated at width clog2(`DEPTH`)+1, so it cannot underflow.
- **When issue = 1:**
  - `rom_en_o` = 1 and `rom_addr_o` = `pc_i`; `pc_inc_o` = 1.
  - Next cycle: `inflight` = 1 and `inflight_addr` = `pc_i`.
- **When issue = 0:** `rom_en_o` = 0 and `pc_inc_o` = 0, so the PC holds.
- **Response:** when `inflight` = 1 and no redirect, {`rom_data_i`, `inflight_addr`} is written at the write pointer.
- **Redirect (`redirect_i` = 1), which has priority over all else:**
  - `pc_load_o` = 1 and `pc_in_o` = `redirect_addr_i`.
  - `rom_en_o` = 0 and `pc_inc_o` = 0.
  - At the edge: count, pointers and `inflight` are all cleared. Any response arriving that cycle is discarded.
  - A pop in the same cycle still counts as accepted by the consumer, but the FIFO is cleared regardless.
- **Outside redirect:** `pc_load_o` = 0 and `pc_in_o` = `redirect_addr_i`; `pc_in_o` is a don't-care then, but it is driven from that input.
- **Head outputs:**
  - `instr_valid_o` = (count != 0).
  - `instr_o` and `instr_pc_o` come from the head entry; they are 0 when empty.
- **Simultaneous write and pop:** count is unchanged and both pointers advance.
- **Wrap-around:** pointers wrap modulo `DEPTH`.
- **Address wrap:** PC 0xFFFF increments to 0x0000 inside the PC. The fetch unit treats the wrapped address as an ordinary address and tags it as such.
- **Reset (asynchronous, any time):**
  - `inflight` = 0, count = 0, pointers = 0, `inflight_addr` = 0.
  - All registered outputs are 0. `instr_valid_o` = 0 immediately.
  - A read in flight when reset is asserted is lost.
  - Combinational outputs resume on the first cycle after `reset_i` falls.

## Timing
- **Latency:** issue in cycle N, ROM data in cycle N+1, written at the end of N+1, `instr_valid_o` high in cycle N+2. There is no bypass path.
- **Throughput:**
  - 1 instruction/cycle sustained with `instr_ready_i` held at 1 and `DEPTH` ≥ 2.
  - Consumer stall: issue stops once count + inflight reaches `DEPTH`. No response is ever dropped for lack of space.
- **Redirect:**
  - Redirect in cycle R: the PC holds the target at R+1; the first issue from the target is at R+1; that instruction is valid at R+3.
  - Back-to-back redirects: the last one wins. Each redirect clears the FIFO and suppresses issue in its own cycle.
- **First fetch after reset:** the first issue is in the first cycle after reset release, at `pc_i` (the PC's reset address).

## Test plan
- **Reset then stream:**
  - Stimulus: ROM[a] = 0x1000+a, `instr_ready_i` held at 1.
  - Required: `instr_valid_o` rises 2 cycles after reset release. Pairs (`instr_pc_o`, `instr_o`) are (0,0x1000), (1,0x1001), (2,0x1002), … on consecutive cycles.
- **Consumer stall:**
  - Stimulus: drop `instr_ready_i` for 5 cycles mid-stream.
  - Required: `rom_en_o` and `pc_inc_o` go low once count + inflight = `DEPTH`. After ready returns, the sequence resumes with no skipped or duplicated address.
- **Redirect to 0x0040 while full with a read in flight:**
  - Required in cycle R: `pc_load_o` = 1 and `pc_in_o` = 0x0040.
  - Required after the edge: `instr_valid_o` = 0.
  - Required at R+3: first valid pair is (0x0040, ROM[0x40]). No stale instruction appears.
- **Redirect coincident with pop and with a ROM response:** the FIFO ends empty and the response is discarded.
- **Address wrap:** PC preset to 0xFFFE with ready held high; required tags are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Asynchronous reset mid-stream:**
  - Stimulus: assert `reset_i` between clock edges.
  - Required: `instr_valid_o` and `rom_en_o` go to 0 without waiting for a clock edge. After release, fetching restarts from the PC reset address.
